// File: rtl/adder_pkg.sv
// Shared constants for the 27-operand signed adder tree.
// Latency tracks the optional input register stage (macro ADDER27_INPUT_REG_EN).
package adder_pkg;

  localparam int BITSIZE_DEF    = 14;
  localparam int NUM_INPUTS_DEF = 27;
  localparam int ADDER_STAGES   = 5;

`ifdef ADDER27_INPUT_REG_EN
  localparam int ADDER_LATENCY = ADDER_STAGES + 1;
`else
  localparam int ADDER_LATENCY = ADDER_STAGES;
`endif

  // Term count entering each stage; the last entry is the single final sum.
  localparam int STAGE_TERMS [ADDER_STAGES+1] = '{27, 14, 7, 4, 2, 1};

  function automatic int out_width(input int bits);
    return bits + 7;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered reduction level: adds adjacent term pairs into width+1 results,
// passing an odd leftover term through sign-extended.
module adder_tree_stage #(
  parameter int N_IN = 27,
  parameter int W_IN = 14,
  localparam int N_OUT = (N_IN + 1) / 2,
  localparam int W_OUT = W_IN + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*W_IN-1:0]   terms_in,
  output logic [N_OUT*W_OUT-1:0] sums_out
);

  logic signed [W_IN-1:0]  term  [N_IN];
  logic signed [W_OUT-1:0] sum_d [N_OUT];
  logic signed [W_OUT-1:0] sum_q [N_OUT];

  for (genvar k = 0; k < N_IN; k++) begin : g_unpack
    assign term[k] = terms_in[k*W_IN +: W_IN];
  end

  always_comb begin
    for (int i = 0; i < N_OUT; i++) sum_d[i] = '0;
    for (int i = 0; i < N_IN / 2; i++) begin
      sum_d[i] = W_OUT'(term[2*i]) + W_OUT'(term[2*i+1]);
    end
    if (N_IN % 2 == 1) sum_d[N_OUT-1] = W_OUT'(term[N_IN-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_OUT; i++) sum_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++) sum_q[i] <= sum_d[i];
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_pack
    assign sums_out[i*W_OUT +: W_OUT] = sum_q[i];
  end

endmodule

// File: rtl/adder_27.sv
// Five-stage pipelined signed adder tree reducing 27 operands to one sum, with a
// matching valid shift register. ADDER27_INPUT_REG_EN adds an input register stage.
module adder_27
  import adder_pkg::*;
#(
  parameter int bitsize    = BITSIZE_DEF,
  parameter int NUM_INPUTS = NUM_INPUTS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_INPUTS*bitsize-1:0] input_numbers,
  input  logic                          start_adder,
  output logic [bitsize+6:0]            sum_output,
  output logic                          data_valid
);

  localparam int OUT_W = out_width(bitsize);
  localparam int W1 = bitsize + 1;
  localparam int W2 = bitsize + 2;
  localparam int W3 = bitsize + 3;
  localparam int W4 = bitsize + 4;
  localparam int W5 = bitsize + ADDER_STAGES;

  if (NUM_INPUTS != STAGE_TERMS[0]) begin : g_bad_cfg
    $error("adder_27: tree is built for exactly 27 operands");
  end

  logic [NUM_INPUTS*bitsize-1:0] tree_in;

`ifdef ADDER27_INPUT_REG_EN
  logic [NUM_INPUTS*bitsize-1:0] in_d, in_q;

  always_comb in_d = input_numbers;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_q <= '0;
    else      in_q <= in_d;
  end

  assign tree_in = in_q;
`else
  assign tree_in = input_numbers;
`endif

  logic [STAGE_TERMS[1]*W1-1:0] s1;
  logic [STAGE_TERMS[2]*W2-1:0] s2;
  logic [STAGE_TERMS[3]*W3-1:0] s3;
  logic [STAGE_TERMS[4]*W4-1:0] s4;
  logic [STAGE_TERMS[5]*W5-1:0] s5;

  adder_tree_stage #(.N_IN(NUM_INPUTS), .W_IN(bitsize)) u_stage1 (
    .clk(clk), .rst(rst), .terms_in(tree_in), .sums_out(s1)
  );
  adder_tree_stage #(.N_IN(STAGE_TERMS[1]), .W_IN(W1)) u_stage2 (
    .clk(clk), .rst(rst), .terms_in(s1), .sums_out(s2)
  );
  adder_tree_stage #(.N_IN(STAGE_TERMS[2]), .W_IN(W2)) u_stage3 (
    .clk(clk), .rst(rst), .terms_in(s2), .sums_out(s3)
  );
  adder_tree_stage #(.N_IN(STAGE_TERMS[3]), .W_IN(W3)) u_stage4 (
    .clk(clk), .rst(rst), .terms_in(s3), .sums_out(s4)
  );
  adder_tree_stage #(.N_IN(STAGE_TERMS[4]), .W_IN(W4)) u_stage5 (
    .clk(clk), .rst(rst), .terms_in(s4), .sums_out(s5)
  );

  // The stage-5 register is the output register; only sign extension remains.
  assign sum_output = {{(OUT_W-W5){s5[W5-1]}}, s5};

  logic [ADDER_LATENCY-1:0] vld_sr_d, vld_sr_q;

  always_comb vld_sr_d = {vld_sr_q[ADDER_LATENCY-2:0], start_adder};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_sr_q <= '0;
    else      vld_sr_q <= vld_sr_d;
  end

  assign data_valid = vld_sr_q[ADDER_LATENCY-1];

endmodule

// File: tb/tb_adder_27.sv
// Directed + random bench for adder_27 against an integer-sum reference with a
// latency-delayed expectation queue.
module tb_adder_27;

  localparam int W   = 14;
  localparam int N   = 27;
  localparam int OW  = 21;
`ifdef ADDER27_INPUT_REG_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  input_numbers;
  logic            start_adder;
  logic [OW-1:0]   sum_output;
  logic            data_valid;

  int vectors = 0;
  int miscompares = 0;
  int ops [N];
  int exp_sum_q [$];
  bit exp_vld_q [$];

  always #5 clk = ~clk;

  adder_27 dut (
    .clk          (clk),
    .rst          (rst),
    .input_numbers(input_numbers),
    .start_adder  (start_adder),
    .sum_output   (sum_output),
    .data_valid   (data_valid)
  );

  // Pipeline after reset holds zeros and no valid.
  task automatic prefill();
    exp_sum_q.delete();
    exp_vld_q.delete();
    for (int i = 0; i < LAT; i++) begin
      exp_sum_q.push_back(0);
      exp_vld_q.push_back(1'b0);
    end
  endtask

  task automatic check_out(input string tag);
    int idx;
    logic [OW-1:0] e_sum;
    logic          e_vld;
    idx   = exp_sum_q.size() - LAT;
    e_sum = OW'(exp_sum_q[idx]);
    e_vld = exp_vld_q[idx];
    assert (sum_output === e_sum) else begin
      miscompares++;
      $error("FAIL %s_sum: observed %0d expected %0d", tag, $signed(sum_output), $signed(e_sum));
    end
    assert (data_valid === e_vld) else begin
      miscompares++;
      $error("FAIL %s_valid: observed %b expected %b", tag, data_valid, e_vld);
    end
  endtask

  task automatic step(input bit st, input string tag);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) begin
      input_numbers[k*W +: W] = ops[k][W-1:0];
      s += ops[k];
    end
    start_adder = st;
    @(posedge clk);
    #1;
    exp_sum_q.push_back(s);
    exp_vld_q.push_back(st);
    vectors++;
    check_out(tag);
  endtask

  task automatic fill_const(input int v);
    for (int k = 0; k < N; k++) ops[k] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) ops[k] = int'($urandom_range(16383)) - 8192;
  endtask

  task automatic check_reset_zero(input string tag);
    assert (sum_output === '0) else begin
      miscompares++;
      $error("FAIL %s_sum: observed %0d expected 0", tag, $signed(sum_output));
    end
    assert (data_valid === 1'b0) else begin
      miscompares++;
      $error("FAIL %s_valid: observed %b expected 0", tag, data_valid);
    end
  endtask

  initial begin
    rst = 1'b0;
    start_adder = 1'b0;
    input_numbers = '0;
    fill_const(0);
    #12;
    check_reset_zero("por");
    @(negedge clk);
    rst = 1'b1;
    prefill();

    // Constant 416 with start held; 27*416 = 11232.
    fill_const(416);
    for (int i = 0; i < LAT + 2; i++) step(1'b1, "c416");
    assert (sum_output === 21'd11232) else begin
      miscompares++;
      $error("FAIL direct416: observed %0d expected 11232", $signed(sum_output));
    end

    // Extremes.
    fill_const(-8192);
    for (int i = 0; i < LAT; i++) step(1'b1, "neg_max");
    assert ($signed(sum_output) === -21'sd221184) else begin
      miscompares++;
      $error("FAIL direct_neg: observed %0d expected -221184", $signed(sum_output));
    end
    fill_const(8191);
    for (int i = 0; i < LAT; i++) step(1'b1, "pos_max");

    // Ramp then doubled negative ramp on the next cycle: 378 then -756.
    for (int k = 0; k < N; k++) ops[k] = k + 1;
    step(1'b1, "ramp");
    for (int k = 0; k < N; k++) ops[k] = -2 * (k + 1);
    step(1'b1, "negramp");
    fill_const(0);
    for (int i = 0; i < LAT; i++) step(1'b0, "ramp_flush");

    // Nonzero data with no qualifier, then a single-cycle pulse.
    for (int i = 0; i < 12; i++) begin
      fill_rand();
      step(1'b0, "idle");
    end
    fill_rand();
    step(1'b1, "pulse");
    for (int i = 0; i < LAT + 4; i++) begin
      fill_rand();
      step(1'b0, "post_pulse");
    end

    // Fill the pipeline with valid data, then reset asynchronously mid-cycle.
    for (int i = 0; i < LAT; i++) begin
      fill_rand();
      step(1'b1, "prereset");
    end
    #2;
    rst = 1'b0;
    #1;
    check_reset_zero("async_rst");
    @(negedge clk);
    check_reset_zero("rst_hold");
    rst = 1'b1;
    prefill();
    for (int i = 0; i < LAT + 2; i++) begin
      fill_rand();
      step(1'b0, "post_rst");
    end

    // Eight distinct vectors back-to-back, then drain.
    for (int i = 0; i < 8; i++) begin
      fill_rand();
      step(1'b1, "b2b");
    end
    for (int i = 0; i < LAT + 1; i++) begin
      fill_rand();
      step(1'b0, "b2b_drain");
    end

    // Random qualifier and data.
    for (int i = 0; i < 200; i++) begin
      fill_rand();
      step(1'($urandom_range(1)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
